serial_negator: RTL and testbench

SERIAL_NEGATOR -- requirements
Module: serial_negator

---
 rtl/serial_negator_if.sv | 36 +++
 rtl/serial_negator.sv | 132 +++++++++++++
 tb/tb_serial_negator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_negator_if.sv
// rtl/serial_negator_if.sv - request/result bundle for the bit-serial negator.
// The master side issues start/mode/a; the slave side returns status and the result.
interface serial_negator_if #(
    parameter int Nsize = 8
);
    logic             start;
    logic             mode;
    logic [Nsize-1:0] a;
    logic             busy;
    logic             done;
    logic [Nsize-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start,
        output mode,
        output a,
        input  busy,
        input  done,
        input  result,
        input  carry_out,
        input  overflow
    );

    modport slave (
        input  start,
        input  mode,
        input  a,
        output busy,
        output done,
        output result,
        output carry_out,
        output overflow
    );
endinterface

// File: rtl/serial_negator.sv
// rtl/serial_negator.sv - bit-serial NOT / two's-complement negate, LSB first.
// One full-add stage per cycle; result, carry_out and overflow publish on SHIFT->DONE.
module serial_negator #(
    parameter int Nsize = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_negator_if.slave bus
);

    localparam int CW = $clog2(Nsize) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(Nsize - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [Nsize-1:0] op_q, op_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [Nsize-1:0] res_sr_q, res_sr_d;
    logic             lo_zero_q, lo_zero_d;
    logic [Nsize-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic             inv_bit;
    logic             sum_bit;
    logic             next_carry;
    logic             last_bit;
    logic [Nsize:0]   res_ext;
    logic [Nsize-1:0] res_shifted;

    // Serial adder stage: adds the running carry to the inverted operand bit.
    always_comb begin
        inv_bit     = ~op_q[0];
        sum_bit     = inv_bit ^ carry_q;
        next_carry  = inv_bit & carry_q;
        last_bit    = (cnt_q == LAST_IDX);
        res_ext     = {sum_bit, res_sr_q};
        res_shifted = res_ext[Nsize:1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            mode_q      <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            res_sr_q    <= '0;
            lo_zero_q   <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mode_q      <= mode_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            res_sr_q    <= res_sr_d;
            lo_zero_q   <= lo_zero_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d        = op_q;
        mode_d      = mode_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        res_sr_d    = res_sr_q;
        lo_zero_d   = lo_zero_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d      = bus.a;
                    mode_d    = bus.mode;
                    carry_d   = bus.mode;
                    cnt_d     = '0;
                    res_sr_d  = '0;
                    lo_zero_d = 1'b1;
                end
            end
            SHIFT: begin
                op_d      = op_q >> 1;
                carry_d   = next_carry;
                cnt_d     = cnt_q + CW'(1);
                res_sr_d  = res_shifted;
                // Tracks whether every bit below the MSB was zero, for overflow.
                lo_zero_d = lo_zero_q & ~op_q[0];
                if (last_bit) begin
                    result_d    = res_shifted;
                    carry_out_d = next_carry;
                    overflow_d  = mode_q & op_q[0] & lo_zero_q;
                end
            end
            default: ;
        endcase
    end

    // Status is decoded purely from state, so start never reaches busy combinationally.
    always_comb begin
        bus.busy      = (state_q == SHIFT) || (state_q == DONE);
        bus.done      = (state_q == DONE);
        bus.result    = result_q;
        bus.carry_out = carry_out_q;
        bus.overflow  = overflow_q;
    end

endmodule

// File: tb/tb_serial_negator.sv
// tb/tb_serial_negator.sv - vector table, corner sequences and random ops vs arithmetic model.
module tb_serial_negator;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_negator_if #(.Nsize(N)) bus ();
    serial_negator #(.Nsize(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [7:0] a;
        logic       mode;
        logic [7:0] exp_r;
        logic       exp_co;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[8];

    int n_checks = 0;
    int n_fail   = 0;
    int hold_err = 0;
    int cyc      = 0;
    logic [7:0] prev_r;
    logic       prev_co, prev_ov;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [9:0] model(input logic [7:0] av, input logic m);
        int v;
        logic [7:0] r;
        logic co, ov;
        v  = int'(av);
        r  = m ? 8'((256 - v) % 256) : 8'(255 - v);
        co = m && (v == 0);
        ov = m && (v == 128);
        return {ov, co, r};
    endfunction

    // Called in the cycle after the accept edge; returns in the DONE cycle.
    task automatic wait_done(output int lat, output int bcnt, input bit scramble);
        lat  = 0;
        bcnt = 0;
        forever begin
            if (bus.busy) bcnt++;
            if (bus.done || lat >= 40) break;
            if (bus.result !== prev_r || bus.carry_out !== prev_co || bus.overflow !== prev_ov)
                hold_err++;
            if (scramble) begin
                bus.a    = 8'($urandom);
                bus.mode = 1'($urandom);
            end
            step();
            lat++;
        end
        check("done_timeout", 32'(bus.done), 32'd1);
        prev_r  = bus.result;
        prev_co = bus.carry_out;
        prev_ov = bus.overflow;
    endtask

    task automatic run_op(input logic [7:0] av, input logic m, output logic [7:0] r,
                          output logic co, output logic ov, output int lat, output int bcnt);
        bus.a     = av;
        bus.mode  = m;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(lat, bcnt, 1'b1);
        r  = bus.result;
        co = bus.carry_out;
        ov = bus.overflow;
        step();
    endtask

    initial begin
        logic [7:0] r, cur_a;
        logic       co, ov, cur_m;
        logic [9:0] exp;
        int         lat, bcnt, last_done;

        vecs[0] = '{8'h5A, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 1'b0, 8'h7F, 1'b0, 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.mode  = 1'b0;
        step();
        step();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", 32'(bus.result), 32'd0);
        check("reset_carry", 32'(bus.carry_out), 32'd0);
        check("reset_ovf", 32'(bus.overflow), 32'd0);
        prev_r  = 8'h00;
        prev_co = 1'b0;
        prev_ov = 1'b0;
        rst     = 1'b0;

        // The first entry starts on the very first edge after reset release.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].mode, r, co, ov, lat, bcnt);
            check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].exp_r));
            check($sformatf("vec%0d_carry", i), 32'(co), 32'(vecs[i].exp_co));
            check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(N));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(N + 1));
        end
        check("idle_after_done", 32'(bus.busy), 32'd0);

        // Inputs disturbed mid-operation, start held through DONE.
        bus.a     = 8'h0F;
        bus.mode  = 1'b1;
        bus.start = 1'b1;
        step();
        bus.a    = 8'hFF;
        bus.mode = 1'b0;
        wait_done(lat, bcnt, 1'b0);
        check("noretrig_latency", 32'(lat), 32'(N));
        check("noretrig_result", 32'(bus.result), 32'hF1);
        check("noretrig_carry", 32'(bus.carry_out), 32'd0);
        check("noretrig_ovf", 32'(bus.overflow), 32'd0);
        step();
        check("held_start_idle", 32'(bus.busy), 32'd0);
        step();
        check("held_start_accepted", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done(lat, bcnt, 1'b1);
        check("held_op_latency", 32'(lat), 32'(N));
        check("held_op_result", 32'(bus.result), 32'h00);
        step();

        // Abort in the fourth SHIFT cycle, with start asserted alongside rst.
        bus.a     = 8'h33;
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("abort_pre_busy", 32'(bus.busy), 32'd1);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_carry", 32'(bus.carry_out), 32'd0);
        check("abort_ovf", 32'(bus.overflow), 32'd0);
        prev_r  = 8'h00;
        prev_co = 1'b0;
        prev_ov = 1'b0;
        run_op(8'h33, 1'b1, r, co, ov, lat, bcnt);
        check("post_abort_latency", 32'(lat), 32'(N));
        check("post_abort_result", 32'(r), 32'hCD);
        check("post_abort_carry", 32'(co), 32'd0);

        // Back-to-back random operations with start held high.
        cur_a     = 8'($urandom);
        cur_m     = 1'($urandom);
        bus.a     = cur_a;
        bus.mode  = cur_m;
        bus.start = 1'b1;
        last_done = -1;
        for (int i = 0; i < 256; i++) begin
            step();
            wait_done(lat, bcnt, 1'b1);
            exp = model(cur_a, cur_m);
            check($sformatf("rnd%0d_result", i), 32'(bus.result), 32'(exp[7:0]));
            check($sformatf("rnd%0d_carry", i), 32'(bus.carry_out), 32'(exp[8]));
            check($sformatf("rnd%0d_ovf", i), 32'(bus.overflow), 32'(exp[9]));
            if (i > 0) check($sformatf("rnd%0d_spacing", i), 32'(cyc - last_done), 32'd10);
            last_done = cyc;
            cur_a    = (i % 37 == 5) ? 8'h80 : ((i % 41 == 7) ? 8'h00 : 8'($urandom));
            cur_m    = 1'($urandom);
            bus.a    = cur_a;
            bus.mode = cur_m;
            step();
        end
        bus.start = 1'b0;
        step();
        step();

        check("result_hold", 32'(hold_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
